main_memory_pipelined: RTL

Registered-read, dual-port instruction/data memory for the RV32I SoC, with a strobe/acknowledge handshake on each port. Read latency is configurable, and the data port has byte-masked writes. Misaligned and out-of-range accesses are flagged instead of aliasing. It sits between `rv32i_core` and the SoC top as the unified instruction-and-data store, for cores or FPGA targets that need synchronous (block-RAM-style) memory.

---
 rtl/main_memory_pipelined.sv | 115 +++++++++++
 1 files changed

// File: rtl/main_memory_pipelined.sv
// Dual-port registered-read instruction/data memory with strobe/ack handshakes,
// configurable read latency, byte-masked data writes and access-fault flagging.
module main_memory_pipelined #(
  parameter int MEMORY_DEPTH = 1024,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_inst_stb,
  input  logic [31:0] i_inst_addr,
  output logic        o_inst_ack,
  output logic [31:0] o_inst_out,
  output logic        o_inst_err,
  input  logic        i_data_stb,
  input  logic        i_data_we,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_in,
  input  logic [3:0]  i_wr_mask,
  output logic        o_data_ack,
  output logic [31:0] o_data_out,
  output logic        o_data_err
);

  localparam int W  = MEMORY_DEPTH / 4;
  localparam int AW = $clog2(MEMORY_DEPTH);
  localparam int IW = AW - 2;

  // Contents power up as zero (block-RAM init image / simulator default);
  // reset deliberately leaves the array untouched.
  logic [31:0] mem_q [W];

  logic [IW-1:0] inst_idx;
  logic [IW-1:0] data_idx;
  logic          inst_fault;
  logic          data_fault;
  logic          wr_en;
  logic [31:0]   merged_word;
  logic [31:0]   inst_rd_d;
  logic [31:0]   data_rd_d;

  logic [READ_LATENCY-1:0] inst_vld_q;
  logic [READ_LATENCY-1:0] inst_err_q;
  logic [31:0]             inst_dat_q [READ_LATENCY];
  logic [READ_LATENCY-1:0] data_vld_q;
  logic [READ_LATENCY-1:0] data_err_q;
  logic [31:0]             data_dat_q [READ_LATENCY];

  assign inst_idx   = i_inst_addr[AW-1:2];
  assign data_idx   = i_data_addr[AW-1:2];
  assign inst_fault = (i_inst_addr >= 32'(MEMORY_DEPTH)) || (i_inst_addr[1:0] != 2'b00);
  assign data_fault = (i_data_addr >= 32'(MEMORY_DEPTH)) || (i_data_addr[1:0] != 2'b00);

  // Gating on i_rst_n keeps the array frozen for as long as reset is held.
  assign wr_en = i_rst_n && i_data_stb && i_data_we && !data_fault;

  always_comb begin
    merged_word = mem_q[data_idx];
    for (int b = 0; b < 4; b++) begin
      if (i_wr_mask[b]) merged_word[8*b +: 8] = i_data_in[8*b +: 8];
    end
  end

  always_comb begin
    inst_rd_d = '0;
    if (i_inst_stb && !inst_fault) begin
      if ((WRITE_FIRST != 0) && wr_en && (inst_idx == data_idx)) inst_rd_d = merged_word;
      else                                                      inst_rd_d = mem_q[inst_idx];
    end
    data_rd_d = '0;
    if (i_data_stb && !i_data_we && !data_fault) data_rd_d = mem_q[data_idx];
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[data_idx] <= merged_word;
  end

  // Stage 0 samples the array; later stages are plain delay registers. Data
  // and err are forced to zero whenever valid is low so outputs idle at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inst_vld_q <= '0;
      inst_err_q <= '0;
      data_vld_q <= '0;
      data_err_q <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        inst_dat_q[k] <= '0;
        data_dat_q[k] <= '0;
      end
    end else begin
      inst_vld_q[0] <= i_inst_stb;
      inst_err_q[0] <= i_inst_stb && inst_fault;
      inst_dat_q[0] <= inst_rd_d;
      data_vld_q[0] <= i_data_stb;
      data_err_q[0] <= i_data_stb && data_fault;
      data_dat_q[0] <= data_rd_d;
      for (int k = 1; k < READ_LATENCY; k++) begin
        inst_vld_q[k] <= inst_vld_q[k-1];
        inst_err_q[k] <= inst_err_q[k-1];
        inst_dat_q[k] <= inst_dat_q[k-1];
        data_vld_q[k] <= data_vld_q[k-1];
        data_err_q[k] <= data_err_q[k-1];
        data_dat_q[k] <= data_dat_q[k-1];
      end
    end
  end

  assign o_inst_ack = inst_vld_q[READ_LATENCY-1];
  assign o_inst_err = inst_err_q[READ_LATENCY-1];
  assign o_inst_out = inst_dat_q[READ_LATENCY-1];
  assign o_data_ack = data_vld_q[READ_LATENCY-1];
  assign o_data_err = data_err_q[READ_LATENCY-1];
  assign o_data_out = data_dat_q[READ_LATENCY-1];

endmodule
